// File: rtl/sm_pkg.sv
// Shared sign-magnitude helpers used by the adder and the sum FIFO:
// the sum-width typedef, the sign-bit index and the conversion to two's complement.
package sm_pkg;

    localparam int SM_DW       = 4;
    localparam int SM_SIGN_BIT = SM_DW;
    localparam int SM_MAX_DW   = 31;

    typedef logic [SM_DW:0]     sm_sum_t;
    typedef logic [SM_MAX_DW:0] sm_wide_t;

    // dw is the magnitude width and must be below SM_MAX_DW. Bit dw is the sign.
    // Negative zero folds to zero because ~0 + 1 wraps to zero inside the mask.
    function automatic sm_wide_t sm_to_twos(input sm_wide_t sm, input int unsigned dw);
        sm_wide_t res_mask;
        sm_wide_t mag_mask;
        sm_wide_t mag;
        sm_wide_t res;
        res_mask = {(SM_MAX_DW + 1){1'b1}} >> (SM_MAX_DW - dw);
        mag_mask = res_mask >> 1;
        mag      = sm & mag_mask;
        if (sm[dw]) begin
            res = (~mag + 32'd1) & res_mask;
        end else begin
            res = mag;
        end
        return res;
    endfunction

endpackage

// File: rtl/sm_fifo_mem.sv
// Storage array for the sum FIFO: one synchronous write port, asynchronous read.
module sm_fifo_mem #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port; contents are left unreset since validity is tracked by the occupancy count.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sm_sum_fifo.sv
// First-word-fall-through FIFO that stores sign-magnitude adder sums as two's complement.
// Optional SM_SUM_FIFO_STATS_EN adds a saturating 16-bit drop_count output.
module sm_sum_fifo
    import sm_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH:0]      in_sum,
    input  logic                     in_valid,
    output logic [DATA_WIDTH:0]      out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef SM_SUM_FIFO_STATS_EN
    ,
    output logic [15:0]              drop_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_not_empty;
    logic [DATA_WIDTH:0]   w_conv;
    logic [DATA_WIDTH:0]   w_rd_data;
    sm_wide_t              w_conv_wide;

    // Handshake decode; a full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        w_not_empty = (r_count != {CW{1'b0}});
        w_pop       = w_not_empty && out_ready;
        if (r_count == FULL_CNT) begin
            w_push = in_valid && w_pop;
            w_drop = in_valid && !w_pop;
        end else begin
            w_push = in_valid;
            w_drop = 1'b0;
        end
        w_conv_wide = sm_to_twos(sm_wide_t'(in_sum), DATA_WIDTH);
        w_conv      = w_conv_wide[DATA_WIDTH:0];
    end

    // Pointers, occupancy and the overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= {PW{1'b0}};
            r_rd_ptr   <= {PW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_overflow <= w_drop;
        end
    end

    sm_fifo_mem #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_conv),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Empty FIFO shows zero so reset and drained states never expose stale storage.
    assign out_valid = w_not_empty;
    assign out_data  = w_not_empty ? w_rd_data : {(DATA_WIDTH + 1){1'b0}};
    assign count     = r_count;
    assign overflow  = r_overflow;

`ifdef SM_SUM_FIFO_STATS_EN
    logic [15:0] r_drop_count;

    // Saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= 16'd0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end else begin
            r_drop_count <= r_drop_count;
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_sm_sum_fifo.sv
// Randomized and directed bench for sm_sum_fifo against a queue-based reference model.
module tb_sm_sum_fifo;

    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW:0]   in_sum;
    logic          in_valid;
    logic          out_ready;
    logic [DW:0]   out_data;
    logic          out_valid;
    logic [CW-1:0] count;
    logic          overflow;
`ifdef SM_SUM_FIFO_STATS_EN
    logic [15:0]   drop_count;
`endif

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [DW:0] q[$];
    logic        exp_ovf;
    int          exp_drops;

    always #5 clk = ~clk;

    sm_sum_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_sum    (in_sum),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
`ifdef SM_SUM_FIFO_STATS_EN
        ,
        .drop_count(drop_count)
`endif
    );

    // Signed value of a sign-magnitude word, truncated to the output width.
    function automatic logic [DW:0] ref_conv(input logic [DW:0] sm);
        int mag;
        int v;
        mag = int'(sm[DW-1:0]);
        v   = sm[DW] ? -mag : mag;
        return v[DW:0];
    endfunction

    function automatic logic [DW:0] exp_head();
        logic [DW:0] z;
        z = '0;
        return (q.size() != 0) ? q[0] : z;
    endfunction

    // Drives one cycle and advances the reference model; no checking here.
    task automatic cycle(input logic v, input logic [DW:0] s, input logic r);
        bit pop, push, full;
        in_valid  = v;
        in_sum    = s;
        out_ready = r;
        pop  = (q.size() != 0) && r;
        full = (q.size() == DEPTH);
        push = v && (!full || pop);
        exp_ovf = v && full && !pop;
        if (exp_ovf && exp_drops < 65535) exp_drops++;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(ref_conv(s));
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_sum = '0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete(); exp_ovf = 1'b0; exp_drops = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1; in_sum = 5'b00111;
        @(posedge clk); @(posedge clk); #1;
        n_cmp++; if (count !== 3'd0) begin n_mis++; $display("FAIL reset_count act=%0d exp=0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid act=%b exp=0", out_valid); end
        n_cmp++; if (overflow !== 1'b0) begin n_mis++; $display("FAIL reset_ovf act=%b exp=0", overflow); end
        n_cmp++; if (out_data !== 5'b00000) begin n_mis++; $display("FAIL reset_data act=%b exp=00000", out_data); end
        in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b1;
        q.delete(); exp_ovf = 1'b0; exp_drops = 0;
`ifdef SM_SUM_FIFO_STATS_EN
        n_cmp++; if (drop_count !== 16'd0) begin n_mis++; $display("FAIL reset_drops act=%0d exp=0", drop_count); end
`endif
    endtask

    task automatic test_conversion();
        logic [DW:0] ins [3];
        logic [DW:0] exps [3];
        ins[0] = 5'b00101; exps[0] = 5'b00101;
        ins[1] = 5'b10101; exps[1] = 5'b11011;
        ins[2] = 5'b10000; exps[2] = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, ins[i], 1'b0);
            n_cmp++; if (out_data !== exps[i]) begin n_mis++; $display("FAIL conv_%0d act=%b exp=%b", i, out_data, exps[i]); end
            n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("FAIL conv_valid_%0d act=%b exp=1", i, out_valid); end
            cycle(1'b0, '0, 1'b1);
            n_cmp++; if (count !== 3'd0) begin n_mis++; $display("FAIL conv_pop_%0d act=%0d exp=0", i, count); end
        end
    endtask

    task automatic test_overflow();
        logic [DW:0] vals [5];
        for (int i = 0; i < 5; i++) vals[i] = 5'($urandom_range(0, 31));
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, vals[i], 1'b0);
            if (i < 4) begin
                n_cmp++; if (overflow !== 1'b0) begin n_mis++; $display("FAIL ovf_early_%0d act=%b exp=0", i, overflow); end
            end else begin
                n_cmp++; if (overflow !== 1'b1) begin n_mis++; $display("FAIL ovf_pulse act=%b exp=1", overflow); end
            end
        end
        n_cmp++; if (count !== 3'd4) begin n_mis++; $display("FAIL ovf_count act=%0d exp=4", count); end
        cycle(1'b0, '0, 1'b0);
        n_cmp++; if (overflow !== 1'b0) begin n_mis++; $display("FAIL ovf_one_cycle act=%b exp=0", overflow); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_data !== ref_conv(vals[i])) begin n_mis++; $display("FAIL ovf_drain_%0d act=%b exp=%b", i, out_data, ref_conv(vals[i])); end
            cycle(1'b0, '0, 1'b1);
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL ovf_empty act=%b exp=0", out_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [DW:0] vals [5];
        for (int i = 0; i < 5; i++) vals[i] = 5'($urandom_range(0, 31));
        for (int i = 0; i < 4; i++) cycle(1'b1, vals[i], 1'b0);
        cycle(1'b1, vals[4], 1'b1);
        n_cmp++; if (count !== 3'd4) begin n_mis++; $display("FAIL fullpp_count act=%0d exp=4", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_mis++; $display("FAIL fullpp_ovf act=%b exp=0", overflow); end
        for (int i = 1; i < 5; i++) begin
            n_cmp++; if (out_data !== ref_conv(vals[i])) begin n_mis++; $display("FAIL fullpp_drain_%0d act=%b exp=%b", i, out_data, ref_conv(vals[i])); end
            cycle(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_wrap();
        logic [DW:0] v;
        for (int i = 0; i < 10; i++) begin
            v = 5'($urandom_range(0, 31));
            cycle(1'b1, v, (i != 0));
            n_cmp++; if (count !== 3'd1) begin n_mis++; $display("FAIL wrap_count_%0d act=%0d exp=1", i, count); end
            n_cmp++; if (out_data !== ref_conv(v)) begin n_mis++; $display("FAIL wrap_data_%0d act=%b exp=%b", i, out_data, ref_conv(v)); end
        end
        cycle(1'b0, '0, 1'b1);
        n_cmp++; if (count !== 3'd0) begin n_mis++; $display("FAIL wrap_end act=%0d exp=0", count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'($urandom_range(0, 31)), 1'b0);
        n_cmp++; if (count !== 3'd3) begin n_mis++; $display("FAIL rmid_pre act=%0d exp=3", count); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_mis++; $display("FAIL rmid_count act=%0d exp=0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL rmid_valid act=%b exp=0", out_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete(); exp_ovf = 1'b0; exp_drops = 0;
        cycle(1'b1, 5'b00011, 1'b0);
        n_cmp++; if (out_data !== 5'b00011) begin n_mis++; $display("FAIL rmid_head act=%b exp=00011", out_data); end
        n_cmp++; if (count !== 3'd1) begin n_mis++; $display("FAIL rmid_count1 act=%0d exp=1", count); end
        cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_random();
        logic v, r;
        logic [DW:0] s;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) == 0);
            s = 5'($urandom_range(0, 31));
            cycle(v, s, r);
            n_cmp++; if (count !== CW'(q.size())) begin n_mis++; $display("FAIL rnd_count_%0d act=%0d exp=%0d", i, count, q.size()); end
            n_cmp++; if (out_valid !== (q.size() != 0)) begin n_mis++; $display("FAIL rnd_valid_%0d act=%b exp=%b", i, out_valid, (q.size() != 0)); end
            n_cmp++; if (out_data !== exp_head()) begin n_mis++; $display("FAIL rnd_data_%0d act=%b exp=%b", i, out_data, exp_head()); end
            n_cmp++; if (overflow !== exp_ovf) begin n_mis++; $display("FAIL rnd_ovf_%0d act=%b exp=%b", i, overflow, exp_ovf); end
`ifdef SM_SUM_FIFO_STATS_EN
            n_cmp++; if (drop_count !== 16'(exp_drops)) begin n_mis++; $display("FAIL rnd_drops_%0d act=%0d exp=%0d", i, drop_count, exp_drops); end
`endif
        end
    endtask

`ifdef SM_SUM_FIFO_STATS_EN
    task automatic test_stats();
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 5'($urandom_range(0, 31)), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'($urandom_range(0, 31)), 1'b0);
        n_cmp++; if (drop_count !== 16'd3) begin n_mis++; $display("FAIL stats_drops act=%0d exp=3", drop_count); end
        n_cmp++; if (count !== 3'd4) begin n_mis++; $display("FAIL stats_count act=%0d exp=4", count); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0;
        exp_ovf = 1'b0; exp_drops = 0;
        test_reset();
        test_conversion();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_reset_mid();
        test_random();
`ifdef SM_SUM_FIFO_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
